interrupt_request_sync: RTL and testbench

- Parametrised, clocked interrupt request register (IRR) for the PIC datapath.
- Synchronises asynchronous IR pins and detects edge or level requests per channel.
- Freezes the IRR during the acknowledge sequence and accepts clears from the in-service/priority logic.
- Feeds the priority resolver. Supersedes the fixed 8-bit combinational IRR that has a single global trigger mode.

---
 rtl/interrupt_request_sync.sv | 111 +++++++++++
 tb/tb_interrupt_request_sync.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/interrupt_request_sync.sv
// interrupt_request_sync
//   Clocked interrupt request register (IRR) for the PIC datapath. Each IR pin
//   is synchronised, then captured per channel as either an edge-latched or a
//   level-tracking request. The IRR holds during the INTA sequence (freeze)
//   and edges seen while frozen are parked in a pending latch until release.
//   Clear strobes from the in-service/priority logic always win.
//
// Parameters
//   NUM_IRQ      number of request channels (1..32)
//   SYNC_STAGES  synchroniser depth per pin (>=2)
//
// Ports
//   clock                   system clock, rising edge
//   reset                   synchronous, active-high reset
//   interrupt_req_pin       asynchronous IR lines
//   level_sel               per channel: 1 = level, 0 = edge
//   freeze                  high during INTA; IRR holds
//   clear_interrupt_req     one-cycle clear strobes per channel
//   interrupt_req_register  registered IRR
//   interrupt_pending       OR of the IRR
//   overrun_clear           (IRR_OVERRUN_EN only) clears overrun_flag bits
//   overrun_flag            (IRR_OVERRUN_EN only) sticky per-channel overrun
//
// Optional feature macro: IRR_OVERRUN_EN
module interrupt_request_sync #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] interrupt_req_pin,
  input  logic [NUM_IRQ-1:0] level_sel,
  input  logic               freeze,
  input  logic [NUM_IRQ-1:0] clear_interrupt_req,
`ifdef IRR_OVERRUN_EN
  input  logic [NUM_IRQ-1:0] overrun_clear,
  output logic [NUM_IRQ-1:0] overrun_flag,
`endif
  output logic [NUM_IRQ-1:0] interrupt_req_register,
  output logic               interrupt_pending
);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] irr_next;
  logic [NUM_IRQ-1:0] pend_next;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;

  // Pending latch only lives while frozen; release (or a clear) empties it.
  assign pend_next = {NUM_IRQ{freeze}} & ~clear_interrupt_req &
                     (pend_q | (rise & ~level_sel));

  always_comb begin
    irr_next = interrupt_req_register;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (clear_interrupt_req[i]) begin
        irr_next[i] = 1'b0;
      end else if (freeze) begin
        irr_next[i] = interrupt_req_register[i];
      end else if (level_sel[i]) begin
        irr_next[i] = s[i];
      end else if (rise[i] || pend_q[i]) begin
        irr_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      prev_q                 <= '0;
      pend_q                 <= '0;
      interrupt_req_register <= '0;
    end else begin
      sync_q[0] <= interrupt_req_pin;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      // prev tracks s even while frozen so a mode change never fakes an edge.
      prev_q                 <= s;
      pend_q                 <= pend_next;
      interrupt_req_register <= irr_next;
    end
  end

  assign interrupt_pending = |interrupt_req_register;

`ifdef IRR_OVERRUN_EN
  logic [NUM_IRQ-1:0] overrun_set;

  // A new edge arriving on a bit that is still requesting (frozen or not).
  assign overrun_set = rise & ~level_sel & interrupt_req_register &
                       ~clear_interrupt_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_flag <= '0;
    end else begin
      overrun_flag <= (overrun_flag & ~overrun_clear) | overrun_set;
    end
  end
`endif

endmodule

// File: tb/tb_interrupt_request_sync.sv
module tb_interrupt_request_sync;

  localparam int N  = 8;
  localparam int SS = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] pin;
  logic [N-1:0] level_sel;
  logic         freeze;
  logic [N-1:0] clr;
  logic [N-1:0] irr;
  logic         pending;
`ifdef IRR_OVERRUN_EN
  logic [N-1:0] ovf_clr;
  logic [N-1:0] ovf;
`endif

  int total = 0;
  int bad   = 0;

  interrupt_request_sync #(.NUM_IRQ(N), .SYNC_STAGES(SS)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .interrupt_req_pin      (pin),
    .level_sel              (level_sel),
    .freeze                 (freeze),
    .clear_interrupt_req    (clr),
`ifdef IRR_OVERRUN_EN
    .overrun_clear          (ovf_clr),
    .overrun_flag           (ovf),
`endif
    .interrupt_req_register (irr),
    .interrupt_pending      (pending)
  );

  always #5 clock = ~clock;

  // Reference model: pin samples are kept as a history list; the synchronised
  // value is the sample taken SS edges back, and the previous sample one
  // further back. Request rules applied per channel on that history.
  logic [N-1:0] hist [SS+1];
  logic [N-1:0] m_irr  = '0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_ovf  = '0;
  bit           model_live = 1'b0;

  initial for (int j = 0; j <= SS; j++) hist[j] = '0;

  always @(posedge clock) begin
    logic [N-1:0] s_v, p_v, r_v, oc;
`ifdef IRR_OVERRUN_EN
    oc = ovf_clr;
`else
    oc = '0;
`endif
    if (reset) begin
      m_irr = '0; m_pend = '0; m_ovf = '0;
      for (int j = 0; j <= SS; j++) hist[j] = '0;
      model_live = 1'b1;
    end else begin
      s_v = hist[SS-1];
      p_v = hist[SS];
      r_v = s_v & ~p_v;
      m_ovf = (m_ovf & ~oc) | (r_v & ~level_sel & m_irr & ~clr);
      for (int i = 0; i < N; i++) begin
        logic nb;
        if (clr[i])            nb = 1'b0;
        else if (freeze)       nb = m_irr[i];
        else if (level_sel[i]) nb = s_v[i];
        else                   nb = m_irr[i] | r_v[i] | m_pend[i];
        if (!freeze || clr[i]) m_pend[i] = 1'b0;
        else if (r_v[i] && !level_sel[i]) m_pend[i] = 1'b1;
        m_irr[i] = nb;
      end
      for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = pin;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_live) begin
      check("model_irr", {24'd0, irr}, {24'd0, m_irr});
      check("model_pending", {31'd0, pending}, {31'd0, |m_irr});
`ifdef IRR_OVERRUN_EN
      check("model_overrun", {24'd0, ovf}, {24'd0, m_ovf});
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; pin = '0; level_sel = '0; freeze = 1'b0; clr = '0;
`ifdef IRR_OVERRUN_EN
    ovf_clr = '0;
`endif
    tick(2);
    reset = 1'b0;
    check("reset_irr", {24'd0, irr}, 32'h0);
    check("reset_pending", {31'd0, pending}, 32'h0);

    // Edge latency on pin[3]
    pin = 8'h08; tick(1); pin = '0;
    tick(1); check("edge_not_early", {24'd0, irr}, 32'h00);
    tick(1); check("edge_lat3", {24'd0, irr}, 32'h08);
    tick(3); check("edge_stays", {24'd0, irr}, 32'h08);
    clr = 8'h08; tick(1); clr = '0;
    check("edge_cleared", {24'd0, irr}, 32'h00);

    // Level tracking on pin[5] with a clear at cycle 6
    level_sel = 8'hFF;
    pin = 8'h20;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i == 5) clr = 8'h20;
      if (i == 6) clr = '0;
      if (i == 2) check("lvl_not_early", {31'd0, irr[5]}, 32'd0);
      if (i == 3) check("lvl_lat3", {31'd0, irr[5]}, 32'd1);
      if (i == 6) check("lvl_clear_gap", {31'd0, irr[5]}, 32'd0);
      if (i == 7) check("lvl_reassert", {31'd0, irr[5]}, 32'd1);
    end
    pin = '0;
    tick(2); check("lvl_hold_2", {31'd0, irr[5]}, 32'd1);
    tick(1); check("lvl_drop_3", {31'd0, irr[5]}, 32'd0);

    // Freeze capture: bit0 edge, bit7 level
    level_sel = 8'h80;
    freeze = 1'b1; tick(1);
    pin = 8'h81; tick(5);
    check("frozen_hold", {24'd0, irr}, 32'h00);
    freeze = 1'b0; tick(1);
    check("freeze_release", {24'd0, irr}, 32'h81);
    pin = '0; tick(4);
    check("lvl7_dropped", {24'd0, irr}, 32'h01);
    clr = 8'h01; tick(1); clr = '0;

    // Clear colliding with the rise on pin[2]
    level_sel = 8'h00;
    pin = 8'h04; tick(2);
    clr = 8'h04; tick(1); clr = '0;
    check("collision", {24'd0, irr}, 32'h00);
    tick(5); check("no_rearm_high", {24'd0, irr}, 32'h00);
    pin = '0; tick(3);

    // Reset mid-operation
    pin = 8'hA5; tick(1); pin = '0; tick(3);
    check("pre_reset_a5", {24'd0, irr}, 32'hA5);
    pin = 8'h02; tick(1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("mid_reset_irr", {24'd0, irr}, 32'h00);
    check("mid_reset_pending", {31'd0, pending}, 32'h0);
    tick(2); check("post_reset_early", {24'd0, irr}, 32'h00);
    tick(1); check("post_reset_lat3", {24'd0, irr}, 32'h02);
    pin = '0; clr = 8'hFF; tick(1); clr = '0; tick(3);

`ifdef IRR_OVERRUN_EN
    pin = 8'h10; tick(3);
    check("ovr_irr_set", {24'd0, irr}, 32'h10);
    check("ovr_flag_idle", {24'd0, ovf}, 32'h00);
    pin = '0; tick(2);
    pin = 8'h10; tick(2);
    tick(1);
    check("ovr_flag_set", {24'd0, ovf}, 32'h10);
    check("ovr_irr_kept", {24'd0, irr}, 32'h10);
    ovf_clr = 8'h10; tick(1); ovf_clr = '0;
    check("ovr_flag_cleared", {24'd0, ovf}, 32'h00);
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
